// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op-field bit positions,
// default operand width and the control FSM state type.
package mul_div_unit_pkg;

  localparam int MULDIV_WIDTH  = 16;

  // op[0] selects DIV over MUL, op[1] selects signed operands
  localparam int OP_DIV_BIT    = 0;
  localparam int OP_SIGNED_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/mul_div_unit_cond_negate.sv
// Two's-complement conditional negation: out = neg ? -in : in.
module cond_negate #(
  parameter int W = 16
) (
  input  logic         neg_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider with sign fix-up, fixed latency
// of WIDTH+2 cycles from start to done, and a destination tag carried through.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH      = MULDIV_WIDTH,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result_lo,
  output logic [WIDTH-1:0]      result_hi,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic                  div_by_zero
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]      acc_q, acc_d;     // MUL: {partial, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]        opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]        a_raw_q, a_raw_d;
  logic                    is_div_q, is_div_d;
  logic                    sign_a_q, sign_a_d;
  logic                    sign_b_q, sign_b_d;
  logic                    b_zero_q, b_zero_d;
  logic [REG_ADDR_W-1:0]   dest_q, dest_d;
  logic [WIDTH-1:0]        lo_q, lo_d, hi_q, hi_d;
  logic [REG_ADDR_W-1:0]   dest_out_q, dest_out_d;
  logic                    dbz_q, dbz_d;

  logic                    op_div, neg_a_in, neg_b_in;
  logic [WIDTH-1:0]        a_mag, b_mag;
  logic [WIDTH:0]          mul_sum, div_trial;
  logic                    div_fits;
  logic [WIDTH-1:0]        div_rem_next;
  logic [2*WIDTH-1:0]      prod_fix;
  logic [WIDTH-1:0]        quo_fix, rem_fix;

  assign op_div   = op[OP_DIV_BIT];
  assign neg_a_in = op[OP_SIGNED_BIT] & a[WIDTH-1];
  assign neg_b_in = op[OP_SIGNED_BIT] & b[WIDTH-1];

  cond_negate #(.W(WIDTH)) u_mag_a (.neg_i(neg_a_in), .in_i(a), .out_o(a_mag));
  cond_negate #(.W(WIDTH)) u_mag_b (.neg_i(neg_b_in), .in_i(b), .out_o(b_mag));

  // Shift-add step: add multiplicand into upper half when the multiplier LSB is set, then shift right
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring step: shift {rem, quo MSB} left, keep the difference only if it did not borrow
  assign div_trial    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
  assign div_fits     = ~div_trial[WIDTH];
  assign div_rem_next = div_fits ? div_trial[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1];

  cond_negate #(.W(2*WIDTH)) u_fix_prod (
    .neg_i(sign_a_q ^ sign_b_q), .in_i(acc_q), .out_o(prod_fix)
  );
  cond_negate #(.W(WIDTH)) u_fix_quo (
    .neg_i(sign_a_q ^ sign_b_q), .in_i(acc_q[WIDTH-1:0]), .out_o(quo_fix)
  );
  cond_negate #(.W(WIDTH)) u_fix_rem (
    .neg_i(sign_a_q), .in_i(acc_q[2*WIDTH-1:WIDTH]), .out_o(rem_fix)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    b_zero_d   = b_zero_q;
    dest_d     = dest_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    dest_out_d = dest_out_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          state_d  = op_div ? ST_DIV : ST_MUL;
          cnt_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
          opnd_d   = op_div ? b_mag : a_mag;
          a_raw_d  = a;
          is_div_d = op_div;
          sign_a_d = neg_a_in;
          sign_b_d = neg_b_in;
          b_zero_d = (b == '0);
          dest_d   = dest_in;
          dbz_d    = 1'b0;
        end
      end
      ST_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) state_d = ST_FIX;
      end
      ST_DIV: begin
        acc_d = {div_rem_next, acc_q[WIDTH-2:0], div_fits};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (!flush) begin
          dest_out_d = dest_q;
          dbz_d      = is_div_q & b_zero_q;
          if (!is_div_q) begin
            lo_d = prod_fix[WIDTH-1:0];
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
          end else if (b_zero_q) begin
            lo_d = '1;
            hi_d = a_raw_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (flush && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      dest_q     <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      dest_out_q <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      b_zero_q   <= b_zero_d;
      dest_q     <= dest_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      dest_out_q <= dest_out_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign result_lo   = lo_q;
  assign result_hi   = hi_q;
  assign dest_out    = dest_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, start, flush;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic [AW-1:0] dest_in;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  result_lo, result_hi;
  logic [AW-1:0] dest_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0]  last_lo   = '0;
  logic [W-1:0]  last_hi   = '0;
  logic [AW-1:0] last_dest = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W), .REG_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .dest_in(dest_in), .flush(flush), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .dest_out(dest_out),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: straight integer arithmetic on 32/64-bit values
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dz);
    longint p;
    int sx, sy, q, r;
    dz = 1'b0;
    if (!o[0]) begin
      p  = o[1] ? longint'($signed(x)) * longint'($signed(y)) : longint'(x) * longint'(y);
      lo = p[15:0];
      hi = p[31:16];
    end else if (y == '0) begin
      lo = '1;
      hi = x;
      dz = 1'b1;
    end else if (o[1]) begin
      sx = $signed(x);
      sy = $signed(y);
      q  = sx / sy;
      r  = sx % sy;
      lo = q[W-1:0];
      hi = r[W-1:0];
    end else begin
      lo = x / y;
      hi = x % y;
    end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  // Called just after a falling edge with the unit idle; returns on the falling edge where busy is low.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [AW-1:0] d, input bit poke);
    logic [W-1:0] e_lo, e_hi;
    logic         e_dz;
    int busy_n = 0, done_n = 0, done_k = -1;
    bit idle_seen = 1'b0;
    model(o, x, y, e_lo, e_hi, e_dz);
    start = 1'b1; op = o; a = x; b = y; dest_in = d;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); dest_in = AW'($urandom);
    check({tag, ":dz_clr"}, div_by_zero, 1'b0);
    for (int k = 0; k < 40 && !idle_seen; k++) begin
      start = 1'b0;
      if (poke && (k == 5 || k == 17)) begin
        start = 1'b1; op = 2'($urandom); dest_in = ~d;
      end
      if (busy) busy_n++;
      else      idle_seen = 1'b1;
      if (done) begin
        done_n++;
        done_k = k;
        check({tag, ":lo"},   result_lo,   e_lo);
        check({tag, ":hi"},   result_hi,   e_hi);
        check({tag, ":dz"},   div_by_zero, e_dz);
        check({tag, ":dest"}, dest_out,    d);
      end
      if (!idle_seen) @(negedge clk);
    end
    check({tag, ":idle"},    idle_seen, 1'b1);
    check({tag, ":lat"},     done_k,    17);
    check({tag, ":busy_n"},  busy_n,    18);
    check({tag, ":done_n"},  done_n,    1);
    check({tag, ":hold_lo"}, result_lo, e_lo);
    check({tag, ":hold_hi"}, result_hi, e_hi);
    if (poke) begin
      @(negedge clk);
      check({tag, ":no_relaunch"}, busy,     1'b0);
      check({tag, ":keep_dest"},   dest_out, d);
    end
    last_lo = e_lo; last_hi = e_hi; last_dest = d;
  endtask

  task automatic run_flush(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [AW-1:0] d, input int at);
    start = 1'b1; op = o; a = x; b = y; dest_in = d;
    @(negedge clk);
    start = 1'b0;
    repeat (at) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check({tag, ":busy"}, busy,        1'b0);
    check({tag, ":done"}, done,        1'b0);
    check({tag, ":lo"},   result_lo,   last_lo);
    check({tag, ":hi"},   result_hi,   last_hi);
    check({tag, ":dest"}, dest_out,    last_dest);
    check({tag, ":dz"},   div_by_zero, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; dest_in = '0;
    repeat (2) @(negedge clk);
    check("rst:busy", busy, 1'b0);
    check("rst:done", done, 1'b0);
    check("rst:lo",   result_lo, '0);
    check("rst:hi",   result_hi, '0);
    check("rst:dest", dest_out, '0);
    check("rst:dz",   div_by_zero, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    run_op("umul_max",   2'b00, 16'hFFFF, 16'hFFFF, 4'h3, 1'b0);
    run_op("smul_neg",   2'b10, 16'hFFFD, 16'h0007, 4'h5, 1'b0);
    run_op("smul_min",   2'b10, 16'h8000, 16'h8000, 4'h6, 1'b0);
    run_op("sdiv_neg",   2'b11, 16'hFFF9, 16'h0002, 4'h7, 1'b0);
    run_op("sdiv_ovf",   2'b11, 16'h8000, 16'hFFFF, 4'h8, 1'b0);
    run_op("udiv_zero",  2'b01, 16'h1234, 16'h0000, 4'h9, 1'b0);
    run_op("udiv_clr",   2'b01, 16'h1234, 16'h0010, 4'hA, 1'b0);
    run_op("sdiv_zero",  2'b11, 16'hF00D, 16'h0000, 4'hB, 1'b0);

    run_flush("flush_div", 2'b01, 16'hBEEF, 16'h0003, 4'hC, 5);
    run_op("after_flush", 2'b11, 16'h7FFF, 16'hFFFE, 4'hD, 1'b0);

    start = 1'b1; flush = 1'b1; op = 2'b00; a = 16'h0002; b = 16'h0003; dest_in = 4'h1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start:busy", busy, 1'b0);
    check("flush_start:lo",   result_lo, last_lo);

    run_op("poke_busy", 2'b00, 16'h0123, 16'h0045, 4'h2, 1'b1);

    for (int i = 0; i < 50; i++) begin
      run_op($sformatf("rand%0d", i), 2'($urandom), pick(), pick(), AW'($urandom), 1'b0);
    end

    start = 1'b1; op = 2'b00; a = 16'h1234; b = 16'h5678; dest_in = 4'hF;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst:busy", busy, 1'b0);
    check("mid_rst:done", done, 1'b0);
    check("mid_rst:lo",   result_lo, '0);
    check("mid_rst:hi",   result_hi, '0);
    check("mid_rst:dest", dest_out, '0);
    check("mid_rst:dz",   div_by_zero, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    last_lo = '0; last_hi = '0; last_dest = '0;
    @(negedge clk);
    run_op("post_rst", 2'b10, 16'h00FF, 16'hFF00, 4'h4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
